// File: rtl/cluster_pwr_sequencer.sv
// Cluster power sequencer: power -> clock -> reset release -> fetch on power-up, reverse on shutdown.
// Define CLUSTER_PWR_SEQ_TIMEOUT_EN to bound the DRAIN wait and raise a sticky error_o on expiry.
module cluster_pwr_sequencer #(
    parameter int unsigned PWR_SETTLE_CYCLES = 16,
    parameter int unsigned RST_CYCLES        = 8,
    parameter int unsigned DRAIN_TIMEOUT     = 1024,
    parameter int unsigned CNT_WIDTH         = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pwr_up_req_i,
    input  logic        pwr_dn_req_i,
    input  logic [63:0] boot_addr_i,
    output logic        req_ack_o,
    output logic        seq_busy_o,
    output logic        error_o,
    output logic [2:0]  state_o,
    output logic        cluster_pow_o,
    output logic        cluster_clk_en_o,
    output logic        cluster_rstn_o,
    output logic        cluster_byp_o,
    output logic        cluster_fetch_enable_o,
    output logic [63:0] cluster_boot_addr_o,
    input  logic        cluster_busy_i
);

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        PWR_ON  = 3'd1,
        CLK_ON  = 3'd2,
        BOOT    = 3'd3,
        RUN     = 3'd4,
        DRAIN   = 3'd5,
        HALT    = 3'd6,
        CLK_OFF = 3'd7
    } state_t;

    localparam int unsigned PS_N = (PWR_SETTLE_CYCLES == 0) ? 1 : PWR_SETTLE_CYCLES;
    localparam int unsigned RS_N = (RST_CYCLES == 0) ? 1 : RST_CYCLES;
    localparam int unsigned DT_N = (DRAIN_TIMEOUT == 0) ? 1 : DRAIN_TIMEOUT;
    localparam logic [CNT_WIDTH-1:0] PS_LOAD = CNT_WIDTH'(PS_N - 1);
    localparam logic [CNT_WIDTH-1:0] RS_LOAD = CNT_WIDTH'(RS_N - 1);
    localparam logic [CNT_WIDTH-1:0] DT_LOAD = CNT_WIDTH'(DT_N - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ack_d, err_d, busy_d;
    logic [63:0]          boot_d;
    logic [4:0]           ctrl_d;   // pow, clk_en, rstn, byp, fetch

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_WIDTH'(1) : cnt_q;
        ack_d   = 1'b0;
        boot_d  = cluster_boot_addr_o;
        err_d   = error_o;
        case (state_q)
            OFF: begin
                // requests are ignored during the ack cycle so a held level is not re-accepted
                if (!req_ack_o) begin
                    if (pwr_up_req_i) begin
                        state_d = PWR_ON;
                        cnt_d   = PS_LOAD;
                        boot_d  = boot_addr_i;
                        err_d   = 1'b0;
                    end else if (pwr_dn_req_i) begin
                        ack_d = 1'b1;
                    end
                end
            end
            PWR_ON: if (cnt_q == '0) begin
                state_d = CLK_ON;
                cnt_d   = RS_LOAD;
            end
            CLK_ON: if (cnt_q == '0) state_d = BOOT;
            BOOT: begin
                state_d = RUN;
                ack_d   = 1'b1;
            end
            RUN: begin
                if (!req_ack_o) begin
                    if (pwr_dn_req_i) begin
                        state_d = DRAIN;
                        cnt_d   = DT_LOAD;
                    end else if (pwr_up_req_i) begin
                        ack_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!cluster_busy_i) begin
                    state_d = HALT;
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
                end else if (cnt_q == '0) begin
                    state_d = HALT;
                    err_d   = 1'b1;
`endif
                end
            end
            HALT:    state_d = CLK_OFF;
            CLK_OFF: begin
                state_d = OFF;
                ack_d   = 1'b1;
            end
            default: state_d = OFF;
        endcase
`ifndef CLUSTER_PWR_SEQ_TIMEOUT_EN
        err_d = 1'b0;
`endif
    end

    always_comb begin
        ctrl_d = 5'b00010;
        case (state_d)
            OFF:     ctrl_d = 5'b00010;
            PWR_ON:  ctrl_d = 5'b10010;
            CLK_ON:  ctrl_d = 5'b11010;
            BOOT:    ctrl_d = 5'b11101;
            RUN:     ctrl_d = 5'b11101;
            DRAIN:   ctrl_d = 5'b11100;
            HALT:    ctrl_d = 5'b11010;
            CLK_OFF: ctrl_d = 5'b10010;
            default: ctrl_d = 5'b00010;
        endcase
        busy_d = (state_d != OFF) && (state_d != RUN);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q                <= OFF;
            cnt_q                  <= '0;
            req_ack_o              <= 1'b0;
            error_o                <= 1'b0;
            seq_busy_o             <= 1'b0;
            cluster_boot_addr_o    <= '0;
            cluster_pow_o          <= 1'b0;
            cluster_clk_en_o       <= 1'b0;
            cluster_rstn_o         <= 1'b0;
            cluster_byp_o          <= 1'b1;
            cluster_fetch_enable_o <= 1'b0;
        end else begin
            state_q                <= state_d;
            cnt_q                  <= cnt_d;
            req_ack_o              <= ack_d;
            error_o                <= err_d;
            seq_busy_o             <= busy_d;
            cluster_boot_addr_o    <= boot_d;
            {cluster_pow_o, cluster_clk_en_o, cluster_rstn_o,
             cluster_byp_o, cluster_fetch_enable_o} <= ctrl_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_cluster_pwr_sequencer.sv
// Directed bench for cluster_pwr_sequencer: expected output snapshots are queued per step
// and compared against the DUT one step later.
module tb_cluster_pwr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        up_req, dn_req, busy;
    logic [63:0] boot_addr;
    logic        ack, seq_busy, err, pow, clk_en, rstn, byp, fetch;
    logic [2:0]  state;
    logic [63:0] c_boot;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        string       tag;
        logic [10:0] v;     // state[2:0], pow, clk_en, rstn, byp, fetch, ack, err, seq_busy
        logic [63:0] addr;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    cluster_pwr_sequencer #(
        .PWR_SETTLE_CYCLES(16),
        .RST_CYCLES(8),
        .DRAIN_TIMEOUT(32),
        .CNT_WIDTH(16)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .pwr_up_req_i(up_req),
        .pwr_dn_req_i(dn_req),
        .boot_addr_i(boot_addr),
        .req_ack_o(ack),
        .seq_busy_o(seq_busy),
        .error_o(err),
        .state_o(state),
        .cluster_pow_o(pow),
        .cluster_clk_en_o(clk_en),
        .cluster_rstn_o(rstn),
        .cluster_byp_o(byp),
        .cluster_fetch_enable_o(fetch),
        .cluster_boot_addr_o(c_boot),
        .cluster_busy_i(busy)
    );

    function automatic logic [10:0] model(input logic [2:0] s, input logic a, input logic e);
        logic [4:0] c;
        case (s)
            3'd0: c = 5'b00010;
            3'd1: c = 5'b10010;
            3'd2: c = 5'b11010;
            3'd3: c = 5'b11101;
            3'd4: c = 5'b11101;
            3'd5: c = 5'b11100;
            3'd6: c = 5'b11010;
            default: c = 5'b10010;
        endcase
        return {s, c, a, e, (s != 3'd0 && s != 3'd4)};
    endfunction

    // queue the expectation, advance one clock, then compare what the DUT produced
    task automatic step(input string tag, input logic [2:0] s, input logic a, input logic e,
                        input logic [63:0] addr);
        exp_t x;
        logic [10:0] obs;
        x.tag = tag; x.v = model(s, a, e); x.addr = addr;
        sb.push_back(x);
        @(posedge clk); #1;
        x = sb.pop_front();
        obs = {state, pow, clk_en, rstn, byp, fetch, ack, err, seq_busy};
        checks++;
        assert (obs === x.v) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", x.tag, obs, x.v);
        end
        checks++;
        assert (c_boot === x.addr) else begin
            errors++;
            $error("FAIL %s_boot: observed=%h expected=%h", x.tag, c_boot, x.addr);
        end
    endtask

    task automatic power_up(input string tag, input logic [63:0] a, input logic e);
        for (int n = 1; n <= 26; n++) begin
            logic [2:0] s;
            s = (n <= 16) ? 3'd1 : (n <= 24) ? 3'd2 : (n == 25) ? 3'd3 : 3'd4;
            step(tag, s, (n == 26), e, a);
        end
    endtask

    localparam logic [63:0] A1 = 64'h1C00_8080;
    localparam logic [63:0] A2 = 64'hDEAD_BEEF_0000_1000;

    initial begin
        rst_n = 1'b0; up_req = 1'b0; dn_req = 1'b0; busy = 1'b0; boot_addr = '0;
        @(posedge clk); #1;
        step("reset", 3'd0, 1'b0, 1'b0, '0);
        rst_n = 1'b1;
        step("idle_off", 3'd0, 1'b0, 1'b0, '0);

        // power-up, ack 26 cycles after the request is sampled
        up_req = 1'b1; boot_addr = A1;
        power_up("up_seq", A1, 1'b0);
        up_req = 1'b0; boot_addr = '0;
        step("run_idle", 3'd4, 1'b0, 1'b0, A1);

        // redundant up in RUN
        up_req = 1'b1;
        step("redund_up", 3'd4, 1'b1, 1'b0, A1);
        up_req = 1'b0;
        step("redund_up_done", 3'd4, 1'b0, 1'b0, A1);

        // shutdown with busy held for 10 cycles
        dn_req = 1'b1; busy = 1'b1;
        for (int i = 0; i < 10; i++) step("drain_busy", 3'd5, 1'b0, 1'b0, A1);
        busy = 1'b0;
        step("halt", 3'd6, 1'b0, 1'b0, A1);
        step("clk_off", 3'd7, 1'b0, 1'b0, A1);
        step("off_ack", 3'd0, 1'b1, 1'b0, A1);
        step("off_ack_hold", 3'd0, 1'b0, 1'b0, A1);
        step("redund_dn", 3'd0, 1'b1, 1'b0, A1);
        dn_req = 1'b0;
        step("redund_dn_done", 3'd0, 1'b0, 1'b0, A1);

        // both requests: up wins in OFF, down wins in RUN
        up_req = 1'b1; dn_req = 1'b1; boot_addr = A2;
        power_up("both_off", A2, 1'b0);
        up_req = 1'b0; dn_req = 1'b0;
        step("both_gap", 3'd4, 1'b0, 1'b0, A2);
        up_req = 1'b1; dn_req = 1'b1;
        step("both_run", 3'd5, 1'b0, 1'b0, A2);
        step("both_halt", 3'd6, 1'b0, 1'b0, A2);
        step("both_clkoff", 3'd7, 1'b0, 1'b0, A2);
        step("both_ack", 3'd0, 1'b1, 1'b0, A2);
        up_req = 1'b0; dn_req = 1'b0;
        step("both_done", 3'd0, 1'b0, 1'b0, A2);

        // reset in the middle of CLK_ON
        up_req = 1'b1; boot_addr = A1;
        for (int n = 1; n <= 20; n++) step("pre_rst", (n <= 16) ? 3'd1 : 3'd2, 1'b0, 1'b0, A1);
        rst_n = 1'b0; up_req = 1'b0;
        step("mid_reset", 3'd0, 1'b0, 1'b0, '0);
        rst_n = 1'b1;
        step("post_reset", 3'd0, 1'b0, 1'b0, '0);

        // drain with busy stuck high
        up_req = 1'b1;
        power_up("up2", A1, 1'b0);
        up_req = 1'b0;
        step("run2", 3'd4, 1'b0, 1'b0, A1);
        dn_req = 1'b1; busy = 1'b1;
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
        for (int i = 0; i < 32; i++) step("drain_to", 3'd5, 1'b0, 1'b0, A1);
        step("to_halt", 3'd6, 1'b0, 1'b1, A1);
        step("to_clkoff", 3'd7, 1'b0, 1'b1, A1);
        step("to_ack", 3'd0, 1'b1, 1'b1, A1);
        dn_req = 1'b0; busy = 1'b0;
        step("to_sticky", 3'd0, 1'b0, 1'b1, A1);
`else
        for (int i = 0; i < 40; i++) step("drain_stuck", 3'd5, 1'b0, 1'b0, A1);
        busy = 1'b0;
        step("stuck_release", 3'd6, 1'b0, 1'b0, A1);
        step("stuck_clkoff", 3'd7, 1'b0, 1'b0, A1);
        step("stuck_ack", 3'd0, 1'b1, 1'b0, A1);
        dn_req = 1'b0;
        step("stuck_done", 3'd0, 1'b0, 1'b0, A1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
